code_deserializer: RTL and testbench

- Downstream stage of the line coder: consumes one 2-bit code symbol per clock, decodes each to a data bit, and reassembles WIDTH-bit words LSB first.
- Delivers each completed word on a valid/ready output handshake and flags illegal symbols.
- Sits between the coder's code output (through the channel model) and word-level consumers and testbenches.

---
 rtl/code_pkg.sv | 17 +
 rtl/code_symbol_decoder.sv | 19 +
 rtl/code_deserializer.sv | 96 +++++++++
 tb/tb_code_deserializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// code_pkg: symbol constants, deserializer FSM states and symbol decode shared with the line coder.
package code_pkg;
    localparam logic [1:0] SYM_ONE     = 2'b00;
    localparam logic [1:0] SYM_ZERO_P  = 2'b01;
    localparam logic [1:0] SYM_ZERO_N  = 2'b10;
    localparam logic [1:0] SYM_ILLEGAL = 2'b11;

    typedef enum logic {COLLECT, FULL} state_e;

    function automatic logic decode_bit(input logic [1:0] s);
        return s == SYM_ONE;
    endfunction

    function automatic logic is_zero_sym(input logic [1:0] s);
        return s == SYM_ZERO_P || s == SYM_ZERO_N;
    endfunction
endpackage

// File: rtl/code_symbol_decoder.sv
// code_symbol_decoder: maps one code symbol to a data bit and an illegal flag.
// With CODE_ALT_CHECK_EN it also flags a zero symbol repeating the previous zero's polarity.
module code_symbol_decoder
    import code_pkg::*;
(
    input  logic [1:0] code_i,
`ifdef CODE_ALT_CHECK_EN
    input  logic [1:0] last_zero_i,
    output logic       alt_err_o,
`endif
    output logic       bit_o,
    output logic       illegal_o
);
    assign bit_o     = decode_bit(code_i);
    assign illegal_o = code_i == SYM_ILLEGAL;
`ifdef CODE_ALT_CHECK_EN
    assign alt_err_o = is_zero_sym(code_i) && code_i == last_zero_i;
`endif
endmodule

// File: rtl/code_deserializer.sv
// code_deserializer: decodes 2-bit code symbols into WIDTH-bit words (LSB first) on a valid/ready output.
// Optional zero-polarity alternation check enabled by CODE_ALT_CHECK_EN.
module code_deserializer
    import code_pkg::*;
#(
    parameter  int WIDTH = 23,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             code_valid_i,
    input  logic [1:0]       code_i,
    input  logic             word_ready_i,
    output logic             word_valid_o,
    output logic [WIDTH-1:0] word_o,
    output logic             sym_err_o,
    output logic             busy_o
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d, word_q, word_d;
    logic             acc_q, acc_d, err_q, err_d;
    logic             dec_bit, illegal, sym_bad;

`ifdef CODE_ALT_CHECK_EN
    logic [1:0] last_zero_q, last_zero_d;
    logic       alt_err;
    code_symbol_decoder u_dec (
        .code_i      (code_i),
        .last_zero_i (last_zero_q),
        .alt_err_o   (alt_err),
        .bit_o       (dec_bit),
        .illegal_o   (illegal)
    );
    assign sym_bad     = illegal | alt_err;
    assign last_zero_d = (code_valid_i && is_zero_sym(code_i)) ? code_i : last_zero_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_zero_q <= SYM_ZERO_N;
        else         last_zero_q <= last_zero_d;
    end
`else
    code_symbol_decoder u_dec (
        .code_i    (code_i),
        .bit_o     (dec_bit),
        .illegal_o (illegal)
    );
    assign sym_bad = illegal;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        word_d  = word_q;
        err_d   = err_q;
        if (state_q == FULL && word_ready_i) state_d = COLLECT;
        // Symbols are taken in every state: the coder upstream cannot be stalled.
        if (code_valid_i) begin
            shift_d = (shift_q & ~(WIDTH'(1) << count_q)) | (WIDTH'(dec_bit) << count_q);
            if (count_q == CNT_W'(WIDTH - 1)) begin
                word_d  = shift_d;
                err_d   = acc_q | sym_bad;
                count_d = '0;
                acc_d   = 1'b0;
                state_d = FULL;
            end else begin
                count_d = count_q + CNT_W'(1);
                acc_d   = acc_q | sym_bad;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            count_q <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    assign word_valid_o = state_q == FULL;
    assign word_o       = word_q;
    assign sym_err_o    = err_q;
    assign busy_o       = count_q != '0;
endmodule

// File: tb/tb_code_deserializer.sv
// tb_code_deserializer: random and directed symbol streams checked against a queue-based word model.
module tb_code_deserializer;
    localparam int W = 23;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         code_valid_i = 1'b0;
    logic [1:0]   code_i = 2'b00;
    logic         word_ready_i = 1'b0;
    logic         word_valid_o;
    logic [W-1:0] word_o;
    logic         sym_err_o;
    logic         busy_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;
    logic [1:0] g_last = 2'b10;

    code_deserializer #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .code_valid_i (code_valid_i),
        .code_i       (code_i),
        .word_ready_i (word_ready_i),
        .word_valid_o (word_valid_o),
        .word_o       (word_o),
        .sym_err_o    (sym_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: symbols of the current word kept as a bit queue.
    logic         mq[$];
    logic         m_err, m_valid, m_held_err, m_bad;
    logic [W-1:0] m_word;
`ifdef CODE_ALT_CHECK_EN
    logic [1:0]   m_last;
`endif
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_err = 0; m_valid = 0; m_held_err = 0; m_word = '0;
`ifdef CODE_ALT_CHECK_EN
            m_last = 2'b10;
`endif
        end else begin
            if (m_valid && word_ready_i) m_valid = 0;
            if (code_valid_i) begin
                m_bad = (code_i == 2'b11);
`ifdef CODE_ALT_CHECK_EN
                if (code_i == 2'b01 || code_i == 2'b10) begin
                    if (code_i == m_last) m_bad = 1;
                    m_last = code_i;
                end
`endif
                mq.push_back(code_i == 2'b00);
                m_err = m_err | m_bad;
                if (mq.size() == W) begin
                    for (int i = 0; i < W; i++) m_word[i] = mq[i];
                    m_held_err = m_err;
                    m_valid = 1;
                    mq.delete();
                    m_err = 0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en && rst_ni) begin
            chk("m_valid", word_valid_o, m_valid);
            chk("m_busy", busy_o, mq.size() != 0);
            if (m_valid) begin
                chk("m_word", word_o, m_word);
                chk("m_err", sym_err_o, m_held_err);
            end
        end
    end

    task automatic cyc(input logic v, input logic [1:0] c, input logic r);
        code_valid_i = v; code_i = c; word_ready_i = r;
        @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b, input logic r);
        logic [1:0] c;
        if (b) c = 2'b00;
        else begin
            c = (g_last == 2'b10) ? 2'b01 : 2'b10;
            g_last = c;
        end
        cyc(1'b1, c, r);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int err_at, input logic r);
        for (int i = 0; i < W; i++) begin
            if (i == err_at) cyc(1'b1, 2'b11, r);
            else send_bit(w[i], r);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        g_last = 2'b10;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w3, wa, wb;
        int n, k;
        repeat (2) @(negedge clk_i);
        chk("rst_word", word_o, 0);
        chk("rst_valid", word_valid_o, 0);
        chk("rst_err", sym_err_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        chk_en = 1;

        send_word(23'd8201481, -1, 1'b1);
        chk("t1_word", word_o, 23'd8201481);
        chk("t1_valid", word_valid_o, 1);
        chk("t1_err", sym_err_o, 0);
        cyc(1'b0, 2'b00, 1'b1);
        chk("t1_pulse", word_valid_o, 0);

        n = 0; k = 0;
        while (!word_valid_o && n < 60) begin
            if (n % 2 == 0 && k < W) begin
                send_bit(W'(8201481) >> k, 1'b1);
                k++;
            end else cyc(1'b0, 2'b00, 1'b1);
            n++;
            if (k > 0 && k < W && !word_valid_o) chk("t2_busy", busy_o, 1);
        end
        chk("t2_lat", n, 45);
        chk("t2_word", word_o, 23'd8201481);
        cyc(1'b0, 2'b00, 1'b1);

        w3 = 23'h2AAAAA;
        send_word(w3, 5, 1'b1);
        chk("t3_bit5", word_o[5], 0);
        chk("t3_word", word_o, 23'h2AAA8A);
        chk("t3_err", sym_err_o, 1);
        send_word(23'h1234, -1, 1'b1);
        chk("t3_clean", sym_err_o, 0);
        chk("t3_word2", word_o, 23'h1234);
        cyc(1'b0, 2'b00, 1'b1);

        wa = 23'h5A5A5A; wb = 23'h0F0F0F;
        send_word(wa, -1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (i < W) send_bit(wb[i], 1'b0);
            else cyc(1'b0, 2'b00, 1'b0);
            chk("t4_hold_valid", word_valid_o, 1);
            chk("t4_word", word_o, (i < W - 1) ? wa : wb);
        end
        cyc(1'b0, 2'b00, 1'b1);
        chk("t4_accept", word_valid_o, 0);

        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk("t5_busy", busy_o, 0);
        chk("t5_word", word_o, 0);
        g_last = 2'b10;
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_word(23'h000155, -1, 1'b1);
        chk("t5_post", word_o, 23'h000155);
        chk("t5_err", sym_err_o, 0);

        do_reset();
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b1, 2'b01, 1'b1);
        for (int i = 2; i < W; i++) cyc(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 1'b1);
        g_last = 2'b10;
        chk("t6_word", word_o, 0);
`ifdef CODE_ALT_CHECK_EN
        chk("t6_alt_err", sym_err_o, 1);
`else
        chk("t6_alt_err", sym_err_o, 0);
`endif
        send_word('0, -1, 1'b1);
        chk("t6_clean", sym_err_o, 0);

        for (int i = 0; i < 1500; i++) begin
            logic v, r;
            int p;
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) != 0;
            p = $urandom % 20;
            if (!v) cyc(1'b0, 2'($urandom), r);
            else if (p == 0) cyc(1'b1, 2'b11, r);
            else if (p == 1) cyc(1'b1, ($urandom % 2) ? 2'b01 : 2'b10, r);
            else send_bit(1'($urandom), r);
            if (i == 700) do_reset();
        end
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
